// File: rtl/rca_seq_pkg.sv
// ----------------------------------------------------------------------------
// rca_seq_pkg
// Shared definitions for the sequential ripple-carry adder with a two-way
// round-robin front end.
//   SLICE_W : width of the shared adder slice (bits processed per cycle)
//   state_e : controller states IDLE -> ADD -> DONE -> IDLE
// ----------------------------------------------------------------------------
package rca_seq_pkg;

    localparam int SLICE_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rca3_slice.sv
// ----------------------------------------------------------------------------
// rca3_slice
// Purely combinational SLICE_W-bit adder slice, reused once per cycle by the
// sequential adder.
// Ports:
//   a_i, b_i  : slice operands
//   cin_i     : carry into the slice
//   sum_o     : slice sum
//   cout_o    : carry out of the slice
// ----------------------------------------------------------------------------
module rca3_slice
    import rca_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               cin_i,
    output logic [SLICE_W-1:0] sum_o,
    output logic               cout_o
);

    // Operands are zero-extended by one bit so the carry-out falls into the
    // extra MSB of the result.
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SLICE_W{1'b0}}, cin_i};

endmodule

// File: rtl/rca_seq_arb.sv
// ----------------------------------------------------------------------------
// rca_seq_arb
// Two requesters share one sequential adder. A round-robin arbiter grants one
// operation at a time while idle; the operands are then summed SLICE_W bits per
// cycle (LSB slice first) through a single rca3_slice, and the result is held
// until the consumer takes it.
// Parameters:
//   NWORDS : number of SLICE_W-bit slices per operand (W = SLICE_W*NWORDS)
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   reqN_valid / reqN_ready           : request handshake for requester N
//   reqN_a, reqN_b, reqN_cin          : requester N operands and carry-in
//   res_valid / res_ready             : result handshake
//   res_sum, res_cout, res_id         : sum, final carry, owning requester
//   res_ovf                           : two's-complement overflow, only present
//                                       when RCA_SEQ_ARB_OVF_EN is defined
// Configuration macro: RCA_SEQ_ARB_OVF_EN
// ----------------------------------------------------------------------------
module rca_seq_arb
    import rca_seq_pkg::*;
#(
    parameter  int NWORDS = 4,
    localparam int W      = SLICE_W * NWORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_cin,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_cin,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_sum,
    output logic         res_cout,
`ifdef RCA_SEQ_ARB_OVF_EN
    output logic         res_ovf,
`endif
    output logic         res_id
);

    localparam int                IDXW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDXW-1:0]   LAST_IDX = IDXW'(NWORDS - 1);

    state_e              state_q;
    logic                lastGrant_q;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic [W-1:0]        acc_q;
    logic [W-1:0]        acc_d;
    logic                carry_q;
    logic                id_q;
    logic [IDXW-1:0]     idx_q;
    logic [W-1:0]        resSum_q;
    logic                resCout_q;
    logic                resId_q;
    logic                resValid_q;
`ifdef RCA_SEQ_ARB_OVF_EN
    logic                resOvf_q;
`endif

    logic                grant0;
    logic                grant1;
    logic [SLICE_W-1:0]  sliceA;
    logic [SLICE_W-1:0]  sliceB;
    logic [SLICE_W-1:0]  sliceSum;
    logic                sliceCout;

    // lastGrant_q = 1 means requester 1 won the previous grant, so requester 0
    // wins the next tie.
    assign grant0     = req0_valid & (~req1_valid | lastGrant_q);
    assign grant1     = req1_valid & (~req0_valid | ~lastGrant_q);
    assign req0_ready = (state_q == IDLE) & grant0;
    assign req1_ready = (state_q == IDLE) & grant1;

    // The carry register is loaded with cin on transfer, so slice 0 sees the
    // latched cin and every later slice sees the previous slice's carry-out.
    assign sliceA = a_q[idx_q*SLICE_W +: SLICE_W];
    assign sliceB = b_q[idx_q*SLICE_W +: SLICE_W];

    rca3_slice u_slice (
        .a_i    (sliceA),
        .b_i    (sliceB),
        .cin_i  (carry_q),
        .sum_o  (sliceSum),
        .cout_o (sliceCout)
    );

    // Accumulated sum with the current slice merged in at its position.
    always_comb begin
        acc_d = acc_q;
        acc_d[idx_q*SLICE_W +: SLICE_W] = sliceSum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            id_q        <= 1'b0;
            idx_q       <= '0;
            resSum_q    <= '0;
            resCout_q   <= 1'b0;
            resId_q     <= 1'b0;
            resValid_q  <= 1'b0;
`ifdef RCA_SEQ_ARB_OVF_EN
            resOvf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_ready | req1_ready) begin
                        a_q         <= req1_ready ? req1_a   : req0_a;
                        b_q         <= req1_ready ? req1_b   : req0_b;
                        carry_q     <= req1_ready ? req1_cin : req0_cin;
                        id_q        <= req1_ready;
                        lastGrant_q <= req1_ready;
                        acc_q       <= '0;
                        idx_q       <= '0;
                        state_q     <= ADD;
                    end
                end
                ADD: begin
                    acc_q   <= acc_d;
                    carry_q <= sliceCout;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        resSum_q   <= acc_d;
                        resCout_q  <= sliceCout;
                        resId_q    <= id_q;
                        resValid_q <= 1'b1;
`ifdef RCA_SEQ_ARB_OVF_EN
                        // Carry into the MSB xor carry out of the MSB.
                        resOvf_q   <= a_q[W-1] ^ b_q[W-1] ^ sliceSum[SLICE_W-1] ^ sliceCout;
`endif
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        resValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    resValid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign res_valid = resValid_q;
    assign res_sum   = resSum_q;
    assign res_cout  = resCout_q;
    assign res_id    = resId_q;
`ifdef RCA_SEQ_ARB_OVF_EN
    assign res_ovf   = resOvf_q;
`endif

endmodule

// File: tb/tb_rca_seq_arb.sv
// ----------------------------------------------------------------------------
// tb_rca_seq_arb
// Directed bench for rca_seq_arb with a result scoreboard. Accepted operations
// push their expected result (from a whole-word reference add) and results
// are popped and compared when the consumer takes them.
// Configuration macro: RCA_SEQ_ARB_OVF_EN (adds res_ovf checking)
// ----------------------------------------------------------------------------
module tb_rca_seq_arb;

    localparam int NWORDS = 4;
    localparam int W      = 3 * NWORDS;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         id;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_cin, req1_cin;
    logic         res_valid, res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout, res_id;
`ifdef RCA_SEQ_ARB_OVF_EN
    logic         res_ovf;
`endif

    exp_t sb[$];
    int   passCount  = 0;
    int   checkCount = 0;
    int   resCount   = 0;
    int   pushedId;
    bit   checkGrant = 1'b0;
    logic expGrant   = 1'b0;

    rca_seq_arb #(.NWORDS(NWORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
`ifdef RCA_SEQ_ARB_OVF_EN
        .res_ovf    (res_ovf),
`endif
        .res_id     (res_id)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Whole-word reference: overflow from operand and result signs.
    function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
        logic [W:0] full;
        full       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        model.sum  = full[W-1:0];
        model.cout = full[W];
        model.id   = id;
        model.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge with inputs settled: records accepted requests and
    // scores results taken by the consumer.
    task automatic monitor();
        exp_t e;
        pushedId = -1;
        checkOutput("one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
        if (req0_valid && req0_ready) begin
            sb.push_back(model(1'b0, req0_a, req0_b, req0_cin));
            pushedId = 0;
        end
        if (req1_valid && req1_ready) begin
            sb.push_back(model(1'b1, req1_a, req1_b, req1_cin));
            pushedId = 1;
        end
        if (pushedId >= 0 && checkGrant) begin
            checkOutput("grant_order", pushedId, {31'd0, expGrant});
            expGrant = ~expGrant;
        end
        if (res_valid) begin
            checkOutput("readies_busy", {30'd0, req0_ready, req1_ready}, 32'd0);
        end
        if (res_valid && res_ready) begin
            if (sb.size() == 0) begin
                checkOutput("sb_nonempty", sb.size(), 32'd1);
            end else begin
                e = sb.pop_front();
                checkOutput("res_sum",  res_sum,  e.sum);
                checkOutput("res_cout", res_cout, e.cout);
                checkOutput("res_id",   res_id,   e.id);
`ifdef RCA_SEQ_ARB_OVF_EN
                checkOutput("res_ovf",  res_ovf,  e.ovf);
`endif
                resCount++;
            end
        end
    endtask

    // One operation from requester id, optionally held in DONE for holdCycles
    // with both requesters pushing (which must not be granted).
    task automatic applyStimulus(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input int holdCycles);
        int n;
        exp_t e;
        if (id) begin
            req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
        end else begin
            req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
        end
        #1;
        checkOutput("grant_ready", {31'd0, id ? req1_ready : req0_ready}, 32'd1);
        monitor();
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        checkOutput("latency", n, NWORDS);
        if (holdCycles > 0 && sb.size() > 0) begin
            e = sb[0];
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            for (int k = 0; k < holdCycles; k++) begin
                #1;
                checkOutput("hold_valid", {31'd0, res_valid}, 32'd1);
                checkOutput("hold_readies", {30'd0, req0_ready, req1_ready}, 32'd0);
                checkOutput("hold_sum", res_sum, e.sum);
                checkOutput("hold_cout", {31'd0, res_cout}, {31'd0, e.cout});
                step();
            end
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        res_ready = 1'b1;
        #1;
        monitor();
        step();
        res_ready = 1'b0;
        #1;
        checkOutput("released", {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        int n;
        int target;
        int p;
        rst_n      = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        res_ready  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("rst_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_sum",   res_sum,  32'd0);
        checkOutput("rst_cout",  {31'd0, res_cout}, 32'd0);
        checkOutput("rst_id",    {31'd0, res_id}, 32'd0);
        rst_n = 1'b1;
        step();

        // Basic add with full carry ripple, then carry-in from requester 1
        applyStimulus(1'b0, 12'hFFF, 12'h001, 1'b0, 0);
        applyStimulus(1'b1, 12'h123, 12'h456, 1'b1, 0);

        // Backpressure: result held for five cycles
        applyStimulus(1'b0, 12'h0A5, 12'hF3C, 1'b1, 5);

        // A few random operations
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 12'($urandom), 12'($urandom), 1'($urandom_range(0, 1)), 0);
        end

        // Contention after reset: grants must alternate starting with 0
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        sb.delete();
        expGrant   = 1'b0;
        checkGrant = 1'b1;
        req0_a = 12'h7FF; req0_b = 12'h001; req0_cin = 1'b0;
        req1_a = 12'h800; req1_b = 12'h800; req1_cin = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        res_ready  = 1'b1;
        #1;
        target = resCount + 4;
        n = 0;
        while (resCount < target && n < 100) begin
            monitor();
            p = pushedId;
            step();
            if (p == 0) begin
                req0_a = 12'($urandom); req0_b = 12'($urandom); req0_cin = 1'($urandom_range(0, 1));
            end else if (p == 1) begin
                req1_a = 12'($urandom); req1_b = 12'($urandom); req1_cin = 1'($urandom_range(0, 1));
            end
            #1;
            n++;
        end
        checkOutput("contention_results", resCount, target);
        checkGrant = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        #1;

        // Reset in the middle of ADD (slice 2 in progress)
        req0_a = 12'h321; req0_b = 12'h654; req0_cin = 1'b1; req0_valid = 1'b1;
        #1;
        monitor();
        step();
        req0_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_add_valid", {31'd0, res_valid}, 32'd0);
        sb.delete();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            checkOutput("no_stale_add", {31'd0, res_valid}, 32'd0);
        end

        // Reset while a result is waiting in DONE
        req1_a = 12'hABC; req1_b = 12'h135; req1_cin = 1'b0; req1_valid = 1'b1;
        #1;
        monitor();
        step();
        req1_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 20) begin
            step();
            n++;
        end
        checkOutput("done_reached", {31'd0, res_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_done_valid", {31'd0, res_valid}, 32'd0);
        checkOutput("rst_done_sum",   res_sum, 32'd0);
        checkOutput("rst_done_id",    {31'd0, res_id}, 32'd0);
        sb.delete();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            checkOutput("no_stale_done", {31'd0, res_valid}, 32'd0);
        end

        // Tie after reset goes to requester 0 again
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checkOutput("tie_after_reset", {30'd0, req0_ready, req1_ready}, 32'd2);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        #1;

        // Overflow corner operands (also scored for sum/cout in every build)
        applyStimulus(1'b0, 12'h7FF, 12'h001, 1'b0, 0);
        applyStimulus(1'b1, 12'hFFF, 12'h001, 1'b0, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/rca_seq_arb.md
RCA_SEQ_ARB -- requirements
Module: rca_seq_arb

Interface
REQ-001 SHALL have parameter NWORDS, default 4, meaning number of 3-bit slices per operand (W = 3*NWORDS).
REQ-002 SHALL have ports clk, input, 1, meaning the single clock.
REQ-003 SHALL have ports rst_n, input, 1, meaning the asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid, input, 1, meaning requester 0 has an operation pending.
REQ-005 SHALL have ports req0_ready, output, 1, meaning requester 0's operation is accepted this cycle.
REQ-006 SHALL have ports req0_a / req0_b, input, W, meaning requester 0 operands.
REQ-007 SHALL have ports req0_cin, input, 1, meaning requester 0 carry-in.
REQ-008 SHALL have ports req1_valid, req1_ready, req1_a, req1_b, req1_cin, identical to REQ-004..007, for requester 1.
REQ-009 SHALL have ports res_valid, output, 1, meaning result available.
REQ-010 SHALL have ports res_ready, input, 1, meaning consumer takes the result.
REQ-011 SHALL have ports res_sum, output, W, meaning the sum.
REQ-012 SHALL have ports res_cout, output, 1, meaning the final carry-out.
REQ-013 SHALL have ports res_id, output, 1, meaning index of the requester that owns the result.

Function
REQ-014 SHALL implement the FSM states IDLE -> ADD -> DONE -> IDLE.
REQ-015 In IDLE, SHALL grant by round-robin: with both valid, grant the requester not granted last; with one valid, grant it.
REQ-016 reqN_ready SHALL be 1 only in IDLE for the granted requester (combinational on valid); the transfer occurs on valid&ready.
REQ-017 On transfer, SHALL latch a, b, cin and id, clear the slice index, and go to ADD.
REQ-018 In ADD, SHALL process one 3-bit slice per cycle, LSB slice first, through one shared 3-bit full-adder slice.
REQ-019 The carry into slice 0 SHALL be the latched cin; each later slice SHALL take the registered carry-out of the previous slice.
REQ-020 After slice NWORDS-1, SHALL register the final carry into res_cout and go to DONE.
REQ-021 Latency SHALL be exactly NWORDS cycles from the transfer edge to res_valid=1.
REQ-022 In DONE, res_valid SHALL be 1, and res_sum/res_cout/res_id SHALL be stable until res_valid&res_ready.
REQ-023 On the res_valid&res_ready edge, SHALL go to IDLE; a new grant is possible the following cycle, never the same cycle.
REQ-024 Requester valid changes during ADD/DONE SHALL have no effect; both readies SHALL be 0 outside IDLE.
REQ-025 Arithmetic SHALL be modulo 2^W with carry in res_cout; {res_cout,res_sum} = a + b + cin exactly.

Reset
REQ-026 rst_n low SHALL asynchronously force IDLE, res_valid=0, res_sum=0, res_cout=0, res_id=0, and the last-grant pointer=1 (first tie goes to requester 0).
REQ-027 A reset mid-ADD or mid-DONE SHALL discard the operation; no result is emitted after reset release.

Configuration
REQ-028 Macro RCA_SEQ_ARB_OVF_EN defined SHALL add output res_ovf, 1 bit, meaning two's-complement overflow = a[W-1]^b[W-1]^res_sum[W-1]^res_cout, registered with res_sum, reset 0.
REQ-029 Without RCA_SEQ_ARB_OVF_EN, the port and its logic SHALL be absent; all else identical.

Structure
REQ-030 Package rca_seq_pkg SHALL hold the FSM state enum (IDLE, ADD, DONE) and the constant SLICE_W=3.
REQ-031 Sub-module rca3_slice SHALL be a combinational 3-bit adder (a, b, cin -> sum, cout), instantiated exactly once.

Verification
REQ-032 Basic add: NWORDS=4, req0 a=0xFFF b=0x001 cin=0 -> res_valid 4 cycles after transfer, sum=0x000, cout=1, id=0.
REQ-033 Carry-in: req1 a=0x123 b=0x456 cin=1 -> sum=0x57A, cout=0, id=1.
REQ-034 Contention: both valid continuously, res_ready=1 -> grants alternate 0,1,0,1, starting with 0 after reset.
REQ-035 Backpressure: res_ready=0 for 5 cycles in DONE -> outputs stable, both readies 0; the result is released on the first res_ready=1.
REQ-036 Reset mid-ADD (slice 2): rst_n pulse -> res_valid=0 immediately, state IDLE, no stale result afterwards.
REQ-037 Overflow (RCA_SEQ_ARB_OVF_EN): a=0x7FF b=0x001 -> sum=0x800, ovf=1; a=0xFFF b=0x001 -> ovf=0.
